// File: rtl/bcd_count_ctrl_if.sv
// Job request channel for bcd_count_ctrl: preset/target/direction offered under valid/ready.
interface bcd_count_ctrl_if #(
   parameter int unsigned NUM_DIGITS = 8
);
   logic                    start_valid;
   logic                    start_ready;
   logic [4*NUM_DIGITS-1:0] preset;
   logic [4*NUM_DIGITS-1:0] target;
   logic                    dir;

   modport master (output start_valid, output preset, output target, output dir,
                   input  start_ready);
   modport slave  (input  start_valid, input  preset, input  target, input  dir,
                   output start_ready);
endinterface

// File: rtl/bcd_count_ctrl.sv
// Sequencer for the BCD counter bank: loads a preset digit by digit, then gates count enables until target.
// Optional macro BCD_COUNT_CTRL_PRESET_CHECK_EN rejects jobs carrying non-BCD nibbles with an err pulse.
module bcd_count_ctrl #(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned TICK_DIV   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   bcd_count_ctrl_if.slave         job_if,
   input  logic                    abort_i,
   input  logic [4*NUM_DIGITS-1:0] count_i,
   output logic                    loadT_o,
   output logic [2:0]              sel_bcd_o,
   output logic [3:0]              toreplace_o,
   output logic                    en_o,
   output logic                    upd_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o
);
   localparam int unsigned W  = 4 * NUM_DIGITS;
   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [W-1:0]    preset_q, preset_d;
   logic [W-1:0]    target_q, target_d;
   logic            dir_q, dir_d;
   logic            accept_c, tick_c, match_c, reject_c;

`ifdef BCD_COUNT_CTRL_PRESET_CHECK_EN
   logic err_q, err_d;

   function automatic logic has_bad_nibble(input logic [W-1:0] v);
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (v[4*i +: 4] > 4'd9) return 1'b1;
      end
      return 1'b0;
   endfunction

   assign reject_c = has_bad_nibble(job_if.preset) || has_bad_nibble(job_if.target);
   assign err_o    = err_q;
`else
   assign reject_c = 1'b0;
   assign err_o    = 1'b0;
`endif

   assign accept_c           = job_if.start_valid && (state_q == S_IDLE);
   assign tick_c             = (tick_q == TW'(TICK_DIV - 1));
   assign match_c            = (count_i == target_q);
   assign job_if.start_ready = (state_q == S_IDLE);
   assign upd_o              = dir_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         tick_q   <= '0;
         preset_q <= '0;
         target_q <= '0;
         dir_q    <= 1'b1;
`ifdef BCD_COUNT_CTRL_PRESET_CHECK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         tick_q   <= tick_d;
         preset_q <= preset_d;
         target_q <= target_d;
         dir_q    <= dir_d;
`ifdef BCD_COUNT_CTRL_PRESET_CHECK_EN
         err_q    <= err_d;
`endif
      end
   end

   // Next state and outputs; abort outranks the count match in every busy state.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      tick_d      = tick_q;
      preset_d    = preset_q;
      target_d    = target_q;
      dir_d       = dir_q;
`ifdef BCD_COUNT_CTRL_PRESET_CHECK_EN
      err_d       = 1'b0;
`endif
      loadT_o     = 1'b0;
      sel_bcd_o   = 3'd0;
      toreplace_o = 4'd0;
      en_o        = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               if (reject_c) begin
`ifdef BCD_COUNT_CTRL_PRESET_CHECK_EN
                  err_d = 1'b1;
`endif
               end else begin
                  preset_d = job_if.preset;
                  target_d = job_if.target;
                  dir_d    = job_if.dir;
                  idx_d    = '0;
                  state_d  = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            loadT_o     = 1'b1;
            sel_bcd_o   = 3'(idx_q);
            toreplace_o = preset_q[4*idx_q +: 4];
            busy_o      = 1'b1;
            if (abort_i) begin
               idx_d   = '0;
               state_d = S_IDLE;
            end else if (idx_q == IW'(NUM_DIGITS - 1)) begin
               idx_d   = '0;
               tick_d  = '0;
               state_d = S_RUN;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         S_RUN: begin
            busy_o = 1'b1;
            en_o   = tick_c && !match_c;
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (match_c) begin
               state_d = S_DONE;
            end else begin
               tick_d = tick_c ? '0 : tick_q + TW'(1);
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench for bcd_count_ctrl: two instances (TICK_DIV 1 and 4) each driving a behavioural BCD counter bank.
module tb_bcd_count_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   bcd_count_ctrl_if #(.NUM_DIGITS(8)) if0 ();
   bcd_count_ctrl_if #(.NUM_DIGITS(8)) if1 ();

   logic        abort0 = 1'b0, abort1 = 1'b0;
   logic [31:0] count0 = '0, count1 = '0;
   logic        loadT0, loadT1, en0, en1, upd0, upd1, busy0, busy1, done0, done1, err0, err1;
   logic [2:0]  sel0, sel1;
   logic [3:0]  trep0, trep1;
   int          en_cnt0 = 0, en_cnt1 = 0;

   bcd_count_ctrl #(.NUM_DIGITS(8), .TICK_DIV(1)) u0 (
      .clk(clk), .rst(rst), .job_if(if0), .abort_i(abort0), .count_i(count0),
      .loadT_o(loadT0), .sel_bcd_o(sel0), .toreplace_o(trep0), .en_o(en0),
      .upd_o(upd0), .busy_o(busy0), .done_o(done0), .err_o(err0));

   bcd_count_ctrl #(.NUM_DIGITS(8), .TICK_DIV(4)) u1 (
      .clk(clk), .rst(rst), .job_if(if1), .abort_i(abort1), .count_i(count1),
      .loadT_o(loadT1), .sel_bcd_o(sel1), .toreplace_o(trep1), .en_o(en1),
      .upd_o(upd1), .busy_o(busy1), .done_o(done1), .err_o(err1));

   function automatic logic [31:0] bcd_step(input logic [31:0] v, input logic up);
      logic [31:0] r;
      logic [3:0]  d;
      r = v;
      for (int i = 0; i < 8; i++) begin
         d = r[4*i +: 4];
         if (up) begin
            if (d == 4'd9) r[4*i +: 4] = 4'd0;
            else begin r[4*i +: 4] = d + 4'd1; return r; end
         end else begin
            if (d == 4'd0) r[4*i +: 4] = 4'd9;
            else begin r[4*i +: 4] = d - 4'd1; return r; end
         end
      end
      return r;
   endfunction

   // Behavioural counter banks plus enable-pulse tallies.
   always @(posedge clk) begin
      if (loadT0) count0[4*sel0 +: 4] <= trep0;
      else if (en0) count0 <= bcd_step(count0, upd0);
      if (loadT1) count1[4*sel1 +: 4] <= trep1;
      else if (en1) count1 <= bcd_step(count1, upd1);
      if (en0) en_cnt0 <= en_cnt0 + 1;
      if (en1) en_cnt1 <= en_cnt1 + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start0(input logic [31:0] p, input logic [31:0] t, input logic d);
      if0.start_valid = 1'b1; if0.preset = p; if0.target = t; if0.dir = d;
      @(negedge clk);
      if0.start_valid = 1'b0;
   endtask

   task automatic start1(input logic [31:0] p, input logic [31:0] t, input logic d);
      if1.start_valid = 1'b1; if1.preset = p; if1.target = t; if1.dir = d;
      @(negedge clk);
      if1.start_valid = 1'b0;
   endtask

   task automatic wait_done0(input string tag, input int budget);
      int n;
      n = 0;
      while (!done0 && n < budget) begin @(negedge clk); n++; end
      check(tag, 32'(done0), 32'd1);
   endtask

   int          snap, k;
   logic [31:0] pv;

   initial begin
      if0.start_valid = 1'b0; if0.preset = '0; if0.target = '0; if0.dir = 1'b1;
      if1.start_valid = 1'b0; if1.preset = '0; if1.target = '0; if1.dir = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(if0.start_ready), 32'd1);
      check("rst_loadT", 32'(loadT0), 32'd0);
      check("rst_sel", 32'(sel0), 32'd0);
      check("rst_trep", 32'(trep0), 32'd0);
      check("rst_en", 32'(en0), 32'd0);
      check("rst_upd", 32'(upd0), 32'd1);
      check("rst_busy", 32'(busy0), 32'd0);
      check("rst_done", 32'(done0), 32'd0);
      check("rst_err", 32'(err0), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Up count 5 -> 9 at full rate.
      start0(32'h0000_0005, 32'h0000_0009, 1'b1);
      for (int i = 0; i < 8; i++) begin
         check("t1_loadT", 32'(loadT0), 32'd1);
         check("t1_sel", 32'(sel0), 32'(i));
         check("t1_trep", 32'(trep0), (i == 0) ? 32'd5 : 32'd0);
         check("t1_en_load", 32'(en0), 32'd0);
         @(negedge clk);
      end
      snap = en_cnt0;
      check("t1_loadT_off", 32'(loadT0), 32'd0);
      wait_done0("t1_done", 50);
      check("t1_count", count0, 32'h0000_0009);
      check("t1_en_pulses", 32'(en_cnt0 - snap), 32'd4);
      check("t1_ready_in_done", 32'(if0.start_ready), 32'd0);
      @(negedge clk);
      check("t1_ready_after", 32'(if0.start_ready), 32'd1);
      check("t1_done_once", 32'(done0), 32'd0);

      // Preset equals target: immediate completion.
      pv = 32'h1234_5678;
      start0(pv, pv, 1'b1);
      for (int i = 0; i < 8; i++) begin
         check("t3_sel", 32'(sel0), 32'(i));
         check("t3_trep", 32'(trep0), 32'(pv[4*i +: 4]));
         @(negedge clk);
      end
      snap = en_cnt0;
      check("t3_run_en", 32'(en0), 32'd0);
      check("t3_run_busy", 32'(busy0), 32'd1);
      @(negedge clk);
      check("t3_done", 32'(done0), 32'd1);
      check("t3_en_pulses", 32'(en_cnt0 - snap), 32'd0);
      @(negedge clk);

      // Abort on the third load cycle, then a fresh job right away.
      start0(32'h0000_0042, 32'h0000_0099, 1'b1);
      @(negedge clk);
      @(negedge clk);
      check("ab_sel", 32'(sel0), 32'd2);
      abort0 = 1'b1;
      @(negedge clk);
      abort0 = 1'b0;
      check("ab_loadT", 32'(loadT0), 32'd0);
      check("ab_busy", 32'(busy0), 32'd0);
      check("ab_done", 32'(done0), 32'd0);
      check("ab_ready", 32'(if0.start_ready), 32'd1);
      start0(32'h0000_0011, 32'h0000_0013, 1'b1);
      check("ab_new_loadT", 32'(loadT0), 32'd1);
      check("ab_new_sel", 32'(sel0), 32'd0);
      check("ab_new_trep", 32'(trep0), 32'd1);
      wait_done0("ab_new_done", 50);
      check("ab_new_count", count0, 32'h0000_0013);
      @(negedge clk);

      // Non-BCD nibble in the preset.
      start0(32'h0000_000A, 32'h0000_000A, 1'b1);
`ifdef BCD_COUNT_CTRL_PRESET_CHECK_EN
      check("bad_err", 32'(err0), 32'd1);
      check("bad_loadT", 32'(loadT0), 32'd0);
      check("bad_ready", 32'(if0.start_ready), 32'd1);
      @(negedge clk);
      check("bad_err_pulse", 32'(err0), 32'd0);
      check("bad_loadT2", 32'(loadT0), 32'd0);
`else
      check("bad_err", 32'(err0), 32'd0);
      check("bad_loadT", 32'(loadT0), 32'd1);
      check("bad_sel", 32'(sel0), 32'd0);
      check("bad_trep", 32'(trep0), 32'hA);
      wait_done0("bad_done", 50);
      @(negedge clk);
`endif

      // Divided tick, down count 10 -> 7.
      start1(32'h0000_0010, 32'h0000_0007, 1'b0);
      check("t2_upd_load", 32'(upd1), 32'd0);
      repeat (8) @(negedge clk);
      snap = en_cnt1;
      k = 0;
      while (!done1 && k < 40) begin
         check("t2_en_phase", 32'(en1), (k % 4 == 3) ? 32'd1 : 32'd0);
         check("t2_upd", 32'(upd1), 32'd0);
         @(negedge clk);
         k++;
      end
      check("t2_done", 32'(done1), 32'd1);
      check("t2_done_cycle", 32'(k), 32'd13);
      check("t2_en_pulses", 32'(en_cnt1 - snap), 32'd3);
      check("t2_count", count1, 32'h0000_0007);
      @(negedge clk);

      // Reset while running.
      start1(32'h0000_0000, 32'h0000_0050, 1'b1);
      repeat (8 + 5) @(negedge clk);
      check("rr_busy_before", 32'(busy1), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rr_en", 32'(en1), 32'd0);
      check("rr_busy", 32'(busy1), 32'd0);
      check("rr_upd", 32'(upd1), 32'd1);
      check("rr_loadT", 32'(loadT1), 32'd0);
      check("rr_done", 32'(done1), 32'd0);
      check("rr_ready", 32'(if1.start_ready), 32'd1);
      rst = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
